// File: rtl/riscv_pkg.sv
// Shared encodings and types for the writeback stage.
package riscv_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned WBSEL_W = 2;
  localparam int unsigned F3_W    = 3;

  // Writeback source select
  localparam logic [WBSEL_W-1:0] WB_NONE = 2'b00;
  localparam logic [WBSEL_W-1:0] WB_ALU  = 2'b01;
  localparam logic [WBSEL_W-1:0] WB_LOAD = 2'b10;
  localparam logic [WBSEL_W-1:0] WB_PC4  = 2'b11;

  // Load funct3 encodings
  localparam logic [F3_W-1:0] F3_LB  = 3'b000;
  localparam logic [F3_W-1:0] F3_LH  = 3'b001;
  localparam logic [F3_W-1:0] F3_LW  = 3'b010;
  localparam logic [F3_W-1:0] F3_LBU = 3'b100;
  localparam logic [F3_W-1:0] F3_LHU = 3'b101;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } wb_state_t;

  // Context captured when a load is accepted, used when its data returns
  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [F3_W-1:0]  funct3;
    logic [1:0]       addr_lo;
  } ld_ctx_t;

endpackage

// File: rtl/writeback_stage_if.sv
// Execute-stage handshake and data-memory return bus into the writeback stage.
interface writeback_stage_if;
  import riscv_pkg::*;

  logic                ex_valid;
  logic                ex_ready;
  logic [REG_W-1:0]    ex_rd;
  logic [WBSEL_W-1:0]  ex_wb_sel;
  logic [XLEN-1:0]     ex_alu_result;
  logic [XLEN-1:0]     ex_pc_plus4;
  logic [F3_W-1:0]     ex_ld_funct3;
  logic                dmem_rvalid;
  logic [XLEN-1:0]     dmem_rdata;

  modport master (
    output ex_valid, ex_rd, ex_wb_sel, ex_alu_result, ex_pc_plus4, ex_ld_funct3,
    output dmem_rvalid, dmem_rdata,
    input  ex_ready
  );

  modport slave (
    input  ex_valid, ex_rd, ex_wb_sel, ex_alu_result, ex_pc_plus4, ex_ld_funct3,
    input  dmem_rvalid, dmem_rdata,
    output ex_ready
  );

endinterface

// File: rtl/writeback_stage_load_align.sv
// Load data alignment and sign/zero extension; flags unsupported funct3.
module load_align
  import riscv_pkg::*;
(
  input  logic [F3_W-1:0] funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data,
  output logic            illegal
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Byte lane picked by the low address bits; halfword only looks at addr[1]
  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  // Extension by load type
  always_comb begin
    data    = '0;
    illegal = 1'b0;
    case (funct3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LW:   data = rdata;
      F3_LBU:  data = {24'd0, byte_sel};
      F3_LHU:  data = {16'd0, half_sel};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: source select, load wait with timeout, registered RF write and forwarding.
module writeback_stage
  import riscv_pkg::*;
#(
  parameter int unsigned LOAD_TIMEOUT = 64,
  parameter int unsigned CNT_W        = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  writeback_stage_if.slave  wb,
  output logic              rf_wr_en,
  output logic [REG_W-1:0]  rf_rd,
  output logic [XLEN-1:0]   rf_result,
  output logic              fwd_valid,
  output logic [REG_W-1:0]  fwd_rd,
  output logic [XLEN-1:0]   fwd_value,
  output logic              ld_err
);

  wb_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  ld_ctx_t           ctx_q, ctx_d;
  logic              wr_en_d;
  logic [REG_W-1:0]  rd_d;
  logic [XLEN-1:0]   res_d;
  logic              err_d;
  logic [XLEN-1:0]   ld_data;
  logic              ld_illegal;
  logic              cnt_last;

  load_align u_load_align (
    .funct3  (ctx_q.funct3),
    .addr_lo (ctx_q.addr_lo),
    .rdata   (wb.dmem_rdata),
    .data    (ld_data),
    .illegal (ld_illegal)
  );

  assign wb.ex_ready = (state_q == IDLE);
  assign cnt_last    = (cnt_q == CNT_W'(LOAD_TIMEOUT - 1));

  // Register file writes land at posedge; decode sees the same values early
  assign fwd_valid = rf_wr_en;
  assign fwd_rd    = rf_rd;
  assign fwd_value = rf_result;

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctx_d   = ctx_q;
    wr_en_d = 1'b0;
    rd_d    = rf_rd;
    res_d   = rf_result;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (wb.ex_valid) begin
          case (wb.ex_wb_sel)
            WB_ALU: begin
              wr_en_d = (wb.ex_rd != '0);
              rd_d    = wb.ex_rd;
              res_d   = wb.ex_alu_result;
            end
            WB_PC4: begin
              wr_en_d = (wb.ex_rd != '0);
              rd_d    = wb.ex_rd;
              res_d   = wb.ex_pc_plus4;
            end
            WB_LOAD: begin
              ctx_d   = '{rd: wb.ex_rd, funct3: wb.ex_ld_funct3, addr_lo: wb.ex_alu_result[1:0]};
              cnt_d   = '0;
              state_d = WAIT_LOAD;
            end
            default: ;
          endcase
        end
      end
      WAIT_LOAD: begin
        // Data arriving on the expiry cycle still wins over the timeout
        if (wb.dmem_rvalid) begin
          state_d = IDLE;
          if (ld_illegal) begin
            err_d = 1'b1;
          end else begin
            wr_en_d = (ctx_q.rd != '0);
            rd_d    = ctx_q.rd;
            res_d   = ld_data;
          end
        end else if (cnt_last) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter, load context and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ctx_q     <= '0;
      rf_wr_en  <= 1'b0;
      rf_rd     <= '0;
      rf_result <= '0;
      ld_err    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ctx_q     <= ctx_d;
      rf_wr_en  <= wr_en_d;
      rf_rd     <= rd_d;
      rf_result <= res_d;
      ld_err    <= err_d;
    end
  end

endmodule
